// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and default bit timing.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 87;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// Producer-side byte handshake for the UART transmitter.
interface uart_transmitter_if;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready;

  modport master (output tx_valid, output tx_byte, input tx_ready);
  modport slave  (input tx_valid, input tx_byte, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through transmit buffer; depth must be a power of two so pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: FIFO feeds a start/data/stop framing FSM with a registered line output.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  uart_transmitter_if.slave         tx_if,
  output logic                      tx,
  output logic                      tx_busy,
  output logic                      tx_done
);
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              ready_en_q;
  logic              fifo_full, fifo_empty, fifo_pop, baud_wrap;
  logic [7:0]        fifo_dout;

  assign tx_if.tx_ready = ready_en_q && !fifo_full;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_if.tx_valid && tx_if.tx_ready),
    .pop   (fifo_pop),
    .din   (tx_if.tx_byte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_wrap = (baud_q == BAUD_MAX);

  // Line level is decoded from the current state and registered, so tx trails the state by one cycle.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    done_d   = 1'b0;
    tx_d     = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = DATA;
        end else baud_d = baud_q + 1'b1;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else baud_d = baud_q + 1'b1;
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else baud_d = baud_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      ready_en_q <= 1'b1;
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: directed stimulus queues expected bytes, a line monitor decodes frames.
module tb_uart_transmitter;
  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, tx_busy, tx_done;
  int unsigned cyc = 0;

  uart_transmitter_if bus_if();

  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_if   (bus_if),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];
  int unsigned done_count = 0;
  int unsigned last_acc = 0;
  bit          mon_active = 0;
  int unsigned mon_idx = 0;
  logic [FRAME-1:0] wave, dbits;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Line monitor: captures FRAME samples from each falling start edge and scores against the queue.
  always @(negedge clk) begin
    if (tx_done) done_count++;
    if (!rst_n) mon_active = 0;
    else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active = 1;
        wave = '0;
        dbits = '0;
        wave[0] = tx;
        dbits[0] = tx_done;
        mon_idx = 1;
        start_q.push_back(cyc);
      end
    end else begin
      wave[mon_idx] = tx;
      dbits[mon_idx] = tx_done;
      mon_idx++;
      if (mon_idx == FRAME) begin
        mon_active = 0;
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [7:0] e, got;
          int unsigned mism;
          logic lvl;
          e = exp_q.pop_front();
          mism = 0;
          for (int unsigned i = 0; i < FRAME; i++) begin
            if (i / CPB == 0) lvl = 1'b0;
            else if (i / CPB == 9) lvl = 1'b1;
            else lvl = e[i / CPB - 1];
            if (wave[i] !== lvl) mism++;
          end
          for (int unsigned j = 0; j < 8; j++) got[j] = wave[(j + 1) * CPB + CPB / 2];
          check("rx_byte", 64'(got), 64'(e));
          check("frame_wave_mismatches", 64'(mism), 64'd0);
          check("done_position", 64'(dbits), 64'd1 << (FRAME - 1));
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bit got, rdy;
    int unsigned n;
    got = 0;
    n = 0;
    @(negedge clk);
    bus_if.tx_valid = 1'b1;
    bus_if.tx_byte  = b;
    while (!got && n < 300) begin
      rdy = bus_if.tx_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        got = 1;
        last_acc = cyc;
        exp_q.push_back(b);
      end else begin
        n++;
        @(negedge clk);
      end
    end
    bus_if.tx_valid = 1'b0;
    check("accept_in_time", 64'(got), 64'd1);
  endtask

  // One-cycle offer with a hand-predicted ready level; expected bytes are queued only where acceptance is predicted.
  task automatic offer(input logic [7:0] b, input logic exp_rdy);
    @(negedge clk);
    bus_if.tx_valid = 1'b1;
    bus_if.tx_byte  = b;
    check("ready_while_filling", 64'(bus_if.tx_ready), 64'(exp_rdy));
    if (exp_rdy) exp_q.push_back(b);
    @(posedge clk);
    #1;
    bus_if.tx_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    bit ok;
    ok = 0;
    for (n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_busy && !mon_active) ok = 1;
    end
    check("drain_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  logic [7:0] stream [20] = '{8'h3A, 8'hC5, 8'h01, 8'h80, 8'h7E, 8'hE7, 8'h42, 8'h99, 8'h10, 8'hF0,
                              8'h0F, 8'hAA, 8'h55, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h13, 8'h64, 8'hFE};

  initial begin
    int unsigned ns, dc, s, low_cnt, busy_cnt;
    bus_if.tx_valid = 1'b0;
    bus_if.tx_byte  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(tx_busy), 64'd0);
    check("rst_done", 64'(tx_done), 64'd0);
    check("rst_ready", 64'(bus_if.tx_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(bus_if.tx_ready), 64'd1);
    repeat (4) @(negedge clk);

    // Single byte latency and frame
    ns = start_q.size();
    send(8'hA5);
    drain();
    check("a5_frames", 64'(start_q.size() - ns), 64'd1);
    if (start_q.size() > ns) check("a5_start_latency", 64'(start_q[ns] - last_acc), 64'd2);

    // Back-to-back frames with one idle cycle between them
    ns = start_q.size();
    dc = done_count;
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    drain();
    check("b2b_frames", 64'(start_q.size() - ns), 64'd3);
    check("b2b_done_pulses", 64'(done_count - dc), 64'd3);
    if (start_q.size() >= ns + 3) begin
      check("b2b_gap_1", 64'(start_q[ns + 1] - start_q[ns]), 64'(FRAME + 1));
      check("b2b_gap_2", 64'(start_q[ns + 2] - start_q[ns + 1]), 64'(FRAME + 1));
    end

    // Fill while a frame is on the line: 4 accepted, 2 dropped
    send(8'h11);
    repeat (2) @(negedge clk);
    check("busy_during_frame", 64'(tx_busy), 64'd1);
    offer(8'h21, 1'b1);
    offer(8'h32, 1'b1);
    offer(8'h43, 1'b1);
    offer(8'h54, 1'b1);
    offer(8'h65, 1'b0);
    offer(8'h76, 1'b0);
    drain();

    // Reset during data bit 3 discards the frame and buffered bytes
    ns = start_q.size();
    send(8'h55);
    send(8'h66);
    for (int unsigned k = 0; k < 200 && start_q.size() == ns; k++) @(negedge clk);
    check("rst_test_started", 64'(start_q.size() - ns), 64'd1);
    s = (start_q.size() > ns) ? start_q[ns] : cyc;
    for (int unsigned k = 0; k < 200 && cyc < s + 4 * CPB + 1; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    dc = done_count;
    @(posedge clk);
    #1;
    check("midframe_rst_tx", 64'(tx), 64'd1);
    check("midframe_rst_busy", 64'(tx_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    low_cnt = 0;
    busy_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx == 1'b0) low_cnt++;
      if (tx_busy) busy_cnt++;
    end
    check("flushed_tx_low_samples", 64'(low_cnt), 64'd0);
    check("flushed_busy_samples", 64'(busy_cnt), 64'd0);
    check("no_done_after_rst", 64'(done_count - dc), 64'd0);
    send(8'h81);
    drain();

    // Stream through pointer wrap-around
    foreach (stream[i]) send(stream[i]);
    drain();

    check("total_done_pulses", 64'(done_count), 64'd30);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clk cycles per serial bit (10 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit buffer entries; power of two, 2..16.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 tx_valid  input  1  producer presents tx_byte for transmission.
REQ-006 tx_byte  input  8  data byte to send.
REQ-007 tx_ready  output  1  high when the FIFO is not full; transfer occurs on a cycle with tx_valid and tx_ready both high.
REQ-008 tx  output  1  serial line, 8N1 frame, idle high.
REQ-009 tx_busy  output  1  high while a frame is on the line (state not IDLE).
REQ-010 tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-011 Frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START when the FIFO is non-empty; pops the head into the shift register.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after the 8th bit period.
- STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-013 tx SHALL be driven from a register; no combinational path from any input to tx.
REQ-014 A byte accepted at edge N into an empty FIFO while in IDLE SHALL drive tx low from edge N+2.
REQ-015 tx_done SHALL be asserted for one cycle on the final cycle of STOP.
REQ-016 If the FIFO is non-empty at STOP exit, the FSM SHALL enter IDLE for exactly one cycle, then START; inter-frame gap is 1 clk beyond the stop bit.
REQ-017 Bit counter SHALL be 3 bits; baud counter SHALL be $clog2(CLKS_PER_BIT) bits; wrap SHALL occur at CLKS_PER_BIT-1, with no off-by-one.
REQ-018 tx_ready SHALL equal not-full; writes while full SHALL be ignored and SHALL NOT corrupt stored data.
REQ-019 Simultaneous push and pop SHALL be legal at any occupancy, including full (pop frees the slot in the same cycle only via the next-cycle tx_ready) and empty (pop is not possible).
REQ-020 Pointer wrap-around SHALL preserve FIFO order for arbitrary stream lengths.

Reset
REQ-021 Under rst_n=0: state=IDLE, tx=1, tx_busy=0, tx_done=0, tx_ready=0 during reset and 1 on the first cycle after release, FIFO empty, counters 0.
REQ-022 Reset asserted mid-frame SHALL force tx=1 at the next edge and discard the frame and all buffered bytes.

Structure
REQ-023 Package uart_pkg SHALL hold the state enum (IDLE, START, DATA, STOP) and the default CLKS_PER_BIT constant, shared with uart_reciever.
REQ-024 The FIFO SHALL be a separate sub-module, uart_tx_fifo (parameters: width 8, FIFO_DEPTH; ports: push, pop, din, dout, full, empty).

Verification (CLKS_PER_BIT=4)
REQ-025 Push 0xA5 at edge 10 -> tx low from edge 12; line sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; tx_done pulses at edge 51.
REQ-026 Push 0x00, 0xFF, 0x3C back to back -> three frames, each followed by 1 idle cycle, with tx_done pulsing exactly 3 times and bytes emitted in order.
REQ-027 Hold tx_valid high with 6 distinct bytes -> tx_ready drops after 4 accepts; only the accepted bytes appear on tx; bytes offered while full are absent.
REQ-028 Assert rst_n=0 during DATA bit 3 of 0x55 -> tx=1 and tx_busy=0 at the next edge, no tx_done, FIFO empty; a subsequent push of 0x81 transmits correctly.
REQ-029 Stream 20 random bytes into the DUT, looped back into uart_reciever at matching CLKS_PER_BIT -> rx_byte sequence equals the input sequence.
